// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory with a
// request/ready handshake and feeds the IF/ID latch, with one skid entry for stalls.
module fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_mem_read,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] if_inst,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pc_next,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] fetch_count
);

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  typedef enum logic [1:0] {IDLE, WAIT, FULL, HALTED} state_t;

  state_t               state, state_n;
  logic [WORD_SIZE-1:0] pc, pc_n;
  logic                 discard, discard_n;
  logic                 halting, halting_n;
  logic [WORD_SIZE-1:0] skid_inst, skid_inst_n;
  logic [WORD_SIZE-1:0] skid_pc, skid_pc_n;
  logic                 mem_read_n;
  logic [WORD_SIZE-1:0] address_n;
  logic [WORD_SIZE-1:0] inst_n, ifpc_n, ifpcn_n, count_n;
  logic                 valid_n;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      halting     <= 1'b0;
      skid_inst   <= '0;
      skid_pc     <= '0;
      i_mem_read  <= 1'b0;
      i_address   <= '0;
      if_inst     <= '0;
      if_pc       <= '0;
      if_pc_next  <= '0;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      discard     <= discard_n;
      halting     <= halting_n;
      skid_inst   <= skid_inst_n;
      skid_pc     <= skid_pc_n;
      i_mem_read  <= mem_read_n;
      i_address   <= address_n;
      if_inst     <= inst_n;
      if_pc       <= ifpc_n;
      if_pc_next  <= ifpcn_n;
      if_valid    <= valid_n;
      fetch_count <= count_n;
    end
  end

  // Next-state and next-output logic; priority is halt > redirect > stall
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    discard_n   = discard;
    halting_n   = halting;
    skid_inst_n = skid_inst;
    skid_pc_n   = skid_pc;
    mem_read_n  = i_mem_read;
    address_n   = i_address;
    inst_n      = if_inst;
    ifpc_n      = if_pc;
    ifpcn_n     = if_pc_next;
    valid_n     = if_valid;
    count_n     = fetch_count;

    // Decode consumes the latch on any unstalled cycle unless refilled below
    if (if_valid && !stall) valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (halt) begin
          valid_n = 1'b0;
          state_n = HALTED;
        end else begin
          mem_read_n = 1'b1;
          address_n  = redirect ? redirect_pc : pc;
          state_n    = WAIT;
          if (redirect) begin
            pc_n    = redirect_pc;
            valid_n = 1'b0;
          end
        end
      end

      WAIT: begin
        if (i_ready) begin
          mem_read_n = 1'b0;
          discard_n  = 1'b0;
          halting_n  = 1'b0;
          state_n    = IDLE;
          if (halt || halting) begin
            valid_n = 1'b0;
            state_n = HALTED;
          end else if (redirect) begin
            pc_n    = redirect_pc;
            valid_n = 1'b0;
          end else if (!discard) begin
            pc_n = pc + ONE;
            if (!if_valid || !stall) begin
              inst_n  = i_data;
              ifpc_n  = pc;
              ifpcn_n = pc + ONE;
              valid_n = 1'b1;
              count_n = fetch_count + ONE;
            end else begin
              skid_inst_n = i_data;
              skid_pc_n   = pc;
              state_n     = FULL;
            end
          end
        end else if (halt || halting) begin
          // Request stays open; its data is thrown away on completion
          halting_n = 1'b1;
          discard_n = 1'b1;
          valid_n   = 1'b0;
        end else if (redirect) begin
          discard_n = 1'b1;
          pc_n      = redirect_pc;
          valid_n   = 1'b0;
        end
      end

      FULL: begin
        if (halt) begin
          valid_n = 1'b0;
          state_n = HALTED;
        end else if (redirect) begin
          pc_n    = redirect_pc;
          valid_n = 1'b0;
          state_n = IDLE;
        end else if (!stall) begin
          inst_n  = skid_inst;
          ifpc_n  = skid_pc;
          ifpcn_n = skid_pc + ONE;
          valid_n = 1'b1;
          count_n = fetch_count + ONE;
          state_n = IDLE;
        end
      end

      HALTED: begin
        mem_read_n = 1'b0;
        valid_n    = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for steady-state fetch plus
// hand-written sequences for stall, redirect, halt, PC wrap and mid-request reset.
module tb_fetch_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         stall, redirect, halt;
  logic [W-1:0] redirect_pc;

  logic         mr0, rdy0, valid0;
  logic [W-1:0] addr0, data0, inst0, pc0, pcn0, cnt0;
  logic         mr1, rdy1, valid1;
  logic [W-1:0] addr1, data1, inst1, pc1, pcn1, cnt1;

  fetch_unit #(.WORD_SIZE(W), .RESET_PC(16'h0000)) u0 (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(mr0), .i_address(addr0), .i_data(data0), .i_ready(rdy0),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .if_inst(inst0), .if_pc(pc0), .if_pc_next(pcn0), .if_valid(valid0),
    .fetch_count(cnt0)
  );

  fetch_unit #(.WORD_SIZE(W), .RESET_PC(16'hFFFF)) u1 (
    .clk(clk), .reset_n(reset_n),
    .i_mem_read(mr1), .i_address(addr1), .i_data(data1), .i_ready(rdy1),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .if_inst(inst1), .if_pc(pc1), .if_pc_next(pcn1), .if_valid(valid1),
    .fetch_count(cnt1)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int mem_cnt = 0;
  bit served  = 1'b0;

  typedef struct {
    logic         stall;
    logic         mr;
    logic [W-1:0] addr;
    logic         valid;
    logic [W-1:0] inst;
    logic [W-1:0] pc;
    logic [W-1:0] pcn;
    logic [W-1:0] cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock edge, then the u0 memory model (mem[a] = 6000+a, ready 2 cycles after request)
  task automatic tick();
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    if (!reset_n) begin
      mem_cnt = 0;
      served  = 1'b0;
    end else if (mr0 && !served) begin
      mem_cnt++;
      if (mem_cnt >= 2) begin
        rdy0    = 1'b1;
        data0   = 16'h6000 + addr0;
        served  = 1'b1;
        mem_cnt = 0;
      end
    end else if (!mr0) begin
      served  = 1'b0;
      mem_cnt = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    rdy0 = 1'b0; rdy1 = 1'b0; data1 = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " u0 mem_read"}, W'(mr0), '0);
    check({tag, " u0 address"},  addr0,   '0);
    check({tag, " u0 valid"},    W'(valid0), '0);
    check({tag, " u0 inst"},     inst0,   '0);
    check({tag, " u0 pc"},       pc0,     '0);
    check({tag, " u0 pc_next"},  pcn0,    '0);
    check({tag, " u0 count"},    cnt0,    '0);
    check({tag, " u1 mem_read"}, W'(mr1), '0);
    check({tag, " u1 valid"},    W'(valid1), '0);
    check({tag, " u1 count"},    cnt1,    '0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!valid0 && k < budget) begin
      tick();
      k++;
    end
    check(name, W'(valid0), W'(1));
  endtask

  initial begin
    data0 = '0;
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h6000, 16'h0000, 16'h0001, 16'h0001};
    vecs[3] = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h6000, 16'h0000, 16'h0001, 16'h0001};
    vecs[4] = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h6000, 16'h0000, 16'h0001, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 16'h0001, 1'b1, 16'h6001, 16'h0001, 16'h0002, 16'h0002};
    vecs[6] = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h6001, 16'h0001, 16'h0002, 16'h0002};
    vecs[7] = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h6001, 16'h0001, 16'h0002, 16'h0002};
    vecs[8] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'h6002, 16'h0002, 16'h0003, 16'h0003};

    // Reset state, then steady fetch of 0,1,2
    do_reset();
    check_zero("reset");
    for (int i = 0; i < 9; i++) begin
      stall = vecs[i].stall;
      tick();
      check($sformatf("vec%0d mem_read", i), W'(mr0), W'(vecs[i].mr));
      check($sformatf("vec%0d address", i),  addr0, vecs[i].addr);
      check($sformatf("vec%0d valid", i),    W'(valid0), W'(vecs[i].valid));
      check($sformatf("vec%0d inst", i),     inst0, vecs[i].inst);
      check($sformatf("vec%0d pc", i),       pc0,   vecs[i].pc);
      check($sformatf("vec%0d pc_next", i),  pcn0,  vecs[i].pcn);
      check($sformatf("vec%0d count", i),    cnt0,  vecs[i].cnt);
    end

    // Stall 5 cycles holding 6000 while the read of address 1 lands in the skid
    do_reset();
    repeat (3) tick();
    check("stall pre inst", inst0, 16'h6000);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d hold", i), {valid0, inst0[14:0]}, {1'b1, 15'h6000});
    end
    check("stall full no request", W'(mr0), '0);
    stall = 1'b0;
    tick();
    check("unstall inst", inst0, 16'h6001);
    check("unstall pc", pc0, 16'h0001);
    check("unstall valid", W'(valid0), W'(1));
    check("unstall count", cnt0, 16'h0002);
    check("unstall no request", W'(mr0), '0);
    tick();
    check("unstall next addr", addr0, 16'h0002);
    wait_valid("fetch2 valid", 8);
    check("fetch2 inst", inst0, 16'h6002);
    check("fetch2 count", cnt0, 16'h0003);

    // Redirect to 0040 one cycle into WAIT for address 3
    tick();
    check("redir wait addr", addr0, 16'h0003);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("redir request kept", W'(mr0), W'(1));
    check("redir valid", W'(valid0), '0);
    tick();
    check("redir drop valid", W'(valid0), '0);
    check("redir drop count", cnt0, 16'h0003);
    tick();
    check("redir new addr", addr0, 16'h0040);
    wait_valid("redir fetch valid", 8);
    check("redir fetch inst", inst0, 16'h6040);
    check("redir fetch pc", pc0, 16'h0040);
    check("redir fetch pc_next", pcn0, 16'h0041);
    check("redir fetch count", cnt0, 16'h0004);

    // Redirect and stall together while FULL
    stall = 1'b1;
    repeat (3) tick();
    check("full mem_read", W'(mr0), '0);
    check("full hold inst", inst0, 16'h6040);
    redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    check("full redir valid", W'(valid0), '0);
    tick();
    check("full redir mem_read", W'(mr0), W'(1));
    check("full redir addr", addr0, 16'h0080);
    stall = 1'b0;
    wait_valid("full redir fetch valid", 8);
    check("full redir inst", inst0, 16'h6080);
    check("full redir count", cnt0, 16'h0005);

    // Halt during WAIT: request held to completion, then nothing forever
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt request kept", W'(mr0), W'(1));
    check("halt valid", W'(valid0), '0);
    tick();
    check("halt done mem_read", W'(mr0), '0);
    for (int i = 0; i < 20; i++) begin
      redirect    = (i % 5 == 0);
      redirect_pc = 16'h0100;
      tick();
      check($sformatf("halted%0d frozen", i),
            {mr0, valid0, cnt0[13:0]}, {1'b0, 1'b0, 14'h0005});
      check($sformatf("halted%0d addr", i), addr0, 16'h0081);
    end
    redirect = 1'b0;

    // RESET_PC=FFFF: PC wrap on the second fetch
    do_reset();
    tick();
    check("wrap first addr", addr1, 16'hFFFF);
    check("wrap first mem_read", W'(mr1), W'(1));
    rdy1 = 1'b1; data1 = 16'h7FFF;
    tick();
    rdy1 = 1'b0;
    check("wrap inst", inst1, 16'h7FFF);
    check("wrap pc", pc1, 16'hFFFF);
    check("wrap pc_next", pcn1, 16'h0000);
    check("wrap count", cnt1, 16'h0001);
    tick();
    check("wrap second addr", addr1, 16'h0000);
    check("wrap second mem_read", W'(mr1), W'(1));

    // Asynchronous reset mid-request, stray ready afterwards is ignored
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async reset");
    tick();
    reset_n = 1'b1;
    rdy0 = 1'b1; data0 = 16'hDEAD;
    rdy1 = 1'b1; data1 = 16'hDEAD;
    tick();
    rdy1 = 1'b0;
    check("restart u0 addr", addr0, 16'h0000);
    check("restart u0 state", {mr0, valid0, cnt0[13:0]}, {1'b1, 1'b0, 14'h0000});
    check("restart u1 addr", addr1, 16'hFFFF);
    check("restart u1 state", {mr1, valid1, cnt1[13:0]}, {1'b1, 1'b0, 14'h0000});
    rdy1 = 1'b1; data1 = 16'h7000;
    tick();
    rdy1 = 1'b0;
    check("restart u1 inst", inst1, 16'h7000);
    check("restart u1 pc", pc1, 16'hFFFF);
    check("restart u1 count", cnt1, 16'h0001);
    wait_valid("restart u0 valid", 4);
    check("restart u0 inst", inst0, 16'h6000);
    check("restart u0 count", cnt0, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
